addr_segregator_q: RTL and testbench

- Queued, parametrised address field splitter for the 4-core MESI cache processor-side front end.
- Accepts processor read/write requests over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents each request's tag/index/block-offset fields and command type to the cache controller over a second valid/ready handshake.
- Field widths come from cache geometry, not hand-set MSB/LSB pairs; illegal commands are flagged.

---
 rtl/addr_segregator_q_if.sv | 32 +++
 rtl/addr_segregator_q.sv | 93 +++++++++
 tb/tb_addr_segregator_q.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_segregator_q_if.sv
// Processor-side request bus and controller-side field bus of the address segregator queue.
// The master side issues requests and consumes split fields; the slave side is the queue.
interface addr_segregator_q_if #(
    parameter int ADDR_WID   = 32,
    parameter int OFFSET_WID = 2,
    parameter int INDEX_WID  = 18
);
    localparam int TAG_WID = ADDR_WID - INDEX_WID - OFFSET_WID;

    logic                  in_valid;
    logic                  in_ready;
    logic                  cmd_rd;
    logic                  cmd_wr;
    logic [ADDR_WID-1:0]   address;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_rd;
    logic                  out_wr;
    logic [TAG_WID-1:0]    tag_proc;
    logic [INDEX_WID-1:0]  index_proc;
    logic [OFFSET_WID-1:0] blk_offset_proc;

    modport master (
        output in_valid, cmd_rd, cmd_wr, address, out_ready,
        input  in_ready, out_valid, out_rd, out_wr, tag_proc, index_proc, blk_offset_proc
    );

    modport slave (
        input  in_valid, cmd_rd, cmd_wr, address, out_ready,
        output in_ready, out_valid, out_rd, out_wr, tag_proc, index_proc, blk_offset_proc
    );
endinterface

// File: rtl/addr_segregator_q.sv
// Queued address splitter: buffers read/write requests in a DEPTH-entry FIFO and
// presents tag/index/offset of the head entry to the cache controller.
module addr_segregator_q #(
    parameter int ADDR_WID   = 32,
    parameter int OFFSET_WID = 2,
    parameter int INDEX_WID  = 18,
    parameter int DEPTH      = 4,
    localparam int TAG_WID   = ADDR_WID - INDEX_WID - OFFSET_WID,
    localparam int CNT_WID   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    addr_segregator_q_if.slave bus,
    input  logic               flush,
    output logic [CNT_WID-1:0] count,
    output logic               err_cmd
);
    localparam int PTR_WID = $clog2(DEPTH);
    localparam logic [CNT_WID-1:0] FULL_CNT = CNT_WID'(DEPTH);
    localparam logic [PTR_WID-1:0] LAST_PTR = PTR_WID'(DEPTH - 1);

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [TAG_WID-1:0]    tag;
        logic [INDEX_WID-1:0]  index;
        logic [OFFSET_WID-1:0] offset;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             in_entry;
    entry_t             head;
    logic [PTR_WID-1:0] wr_ptr;
    logic [PTR_WID-1:0] rd_ptr;
    logic               accept;
    logic               push;
    logic               pop;
    logic               bad_cmd;

    assign bus.in_ready  = (count != FULL_CNT) && !flush;
    assign bus.out_valid = (count != '0);

    // A handshake with no command, or with both, completes without occupying a slot.
    assign accept  = bus.in_valid && bus.in_ready;
    assign bad_cmd = bus.cmd_rd && bus.cmd_wr;
    assign push    = accept && (bus.cmd_rd ^ bus.cmd_wr);
    assign pop     = bus.out_valid && bus.out_ready && !flush;

    always_comb begin
        in_entry        = '0;
        in_entry.rd     = bus.cmd_rd;
        in_entry.wr     = bus.cmd_wr;
        in_entry.tag    = bus.address[ADDR_WID-1 -: TAG_WID];
        in_entry.index  = bus.address[OFFSET_WID +: INDEX_WID];
        in_entry.offset = bus.address[OFFSET_WID-1:0];
    end

    // Idle-zero outputs: nothing stale leaks out while the queue is empty.
    assign head                = bus.out_valid ? mem[rd_ptr] : '0;
    assign bus.out_rd          = head.rd;
    assign bus.out_wr          = head.wr;
    assign bus.tag_proc        = head.tag;
    assign bus.index_proc      = head.index;
    assign bus.blk_offset_proc = head.offset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cmd <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_cmd <= 1'b0;
        end else begin
            err_cmd <= accept && bad_cmd;
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && count == FULL_CNT));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && count == '0));
    a_count_range:  assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_CNT);
endmodule

// File: tb/tb_addr_segregator_q.sv
// Self-checking bench for addr_segregator_q: directed scenarios plus a randomized run
// against a queue-based reference model (DEPTH=4 instance, plus a DEPTH=3 instance for wrap).
module tb_addr_segregator_q;
    localparam int AW = 32;
    localparam int OW = 2;
    localparam int IW = 18;
    localparam int TW = AW - IW - OW;
    localparam int D  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush4, flush3, err4, err3;
    logic [2:0] cnt4;
    logic [1:0] cnt3;

    always #5 clk = ~clk;

    addr_segregator_q_if #(.ADDR_WID(AW), .OFFSET_WID(OW), .INDEX_WID(IW)) b4 ();
    addr_segregator_q_if #(.ADDR_WID(AW), .OFFSET_WID(OW), .INDEX_WID(IW)) b3 ();

    addr_segregator_q #(.ADDR_WID(AW), .OFFSET_WID(OW), .INDEX_WID(IW), .DEPTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4), .flush(flush4), .count(cnt4), .err_cmd(err4));
    addr_segregator_q #(.ADDR_WID(AW), .OFFSET_WID(OW), .INDEX_WID(IW), .DEPTH(3)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(b3), .flush(flush3), .count(cnt3), .err_cmd(err3));

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
    } req_t;

    req_t mq[$];
    bit   exp_err;
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic logic [TW-1:0] f_tag(logic [31:0] a);
        return TW'(a / (32'd1 << (IW + OW)));
    endfunction
    function automatic logic [IW-1:0] f_idx(logic [31:0] a);
        return IW'((a / (32'd1 << OW)) % (32'd1 << IW));
    endfunction
    function automatic logic [OW-1:0] f_off(logic [31:0] a);
        return OW'(a % (32'd1 << OW));
    endfunction

    task automatic drive4(bit v, bit rd, bit wr, logic [31:0] a, bit ordy, bit fl);
        b4.in_valid = v; b4.cmd_rd = rd; b4.cmd_wr = wr; b4.address = a;
        b4.out_ready = ordy; flush4 = fl;
    endtask

    // Reference model of the DEPTH=4 queue: advances one clock edge, returns to the negedge.
    task automatic model_edge4(output bit acc, output bit popped);
        @(posedge clk);
        acc    = b4.in_valid && (mq.size() != D) && !flush4;
        popped = (mq.size() != 0) && b4.out_ready && !flush4;
        if (flush4) begin
            mq.delete();
            exp_err = 1'b0;
        end else begin
            exp_err = acc && b4.cmd_rd && b4.cmd_wr;
            if (popped) void'(mq.pop_front());
            if (acc && (b4.cmd_rd != b4.cmd_wr)) mq.push_back('{rd: b4.cmd_rd, wr: b4.cmd_wr, a: b4.address});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++; if (b4.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", b4.out_valid); else n_pass++;
        n_checks++; if (b4.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", b4.in_ready); else n_pass++;
        n_checks++; if (cnt4 !== 3'd0) $display("FAIL reset_count got %0d exp 0", cnt4); else n_pass++;
        n_checks++; if ({b4.out_rd, b4.out_wr, b4.tag_proc, b4.index_proc, b4.blk_offset_proc, err4} !== '0)
            $display("FAIL reset_fields got %b%b %h %h %h %b exp all 0", b4.out_rd, b4.out_wr, b4.tag_proc,
                     b4.index_proc, b4.blk_offset_proc, err4);
        else n_pass++;
    endtask

    task automatic test_single_write();
        bit acc, pp;
        drive4(1, 0, 1, 32'hABCDE123, 1, 0);
        model_edge4(acc, pp);
        drive4(0, 0, 0, 32'h0, 1, 0);
        #1;
        n_checks++; if (b4.out_valid !== 1'b1) $display("FAIL single_out_valid got %b exp 1", b4.out_valid); else n_pass++;
        n_checks++; if ({b4.out_rd, b4.out_wr} !== 2'b01) $display("FAIL single_cmd got %b%b exp 01", b4.out_rd, b4.out_wr); else n_pass++;
        n_checks++; if (b4.tag_proc !== 12'hABC) $display("FAIL single_tag got %h exp abc", b4.tag_proc); else n_pass++;
        n_checks++; if (b4.index_proc !== 18'h37848) $display("FAIL single_index got %h exp 37848", b4.index_proc); else n_pass++;
        n_checks++; if (b4.blk_offset_proc !== 2'h3) $display("FAIL single_offset got %h exp 3", b4.blk_offset_proc); else n_pass++;
        model_edge4(acc, pp);
        n_checks++; if (b4.out_valid !== 1'b0 || cnt4 !== 3'd0) $display("FAIL single_drain got valid %b count %0d exp 0 0", b4.out_valid, cnt4); else n_pass++;
        n_checks++; if ({b4.out_wr, b4.tag_proc, b4.index_proc, b4.blk_offset_proc} !== '0)
            $display("FAIL single_idle_zero got %b %h %h %h exp 0", b4.out_wr, b4.tag_proc, b4.index_proc, b4.blk_offset_proc);
        else n_pass++;
    endtask

    task automatic test_fill_full();
        logic [31:0] addrs [5];
        int idx = 0, npop = 0;
        bit acc, pp;
        foreach (addrs[i]) addrs[i] = $urandom;
        for (int k = 0; k < 6; k++) begin
            drive4(idx < 5, 1, 0, addrs[idx < 5 ? idx : 0], 0, 0);
            model_edge4(acc, pp);
            if (acc) idx++;
        end
        drive4(1, 1, 0, addrs[4], 0, 0);
        #1;
        n_checks++; if (cnt4 !== 3'd4) $display("FAIL full_count got %0d exp 4", cnt4); else n_pass++;
        n_checks++; if (b4.in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", b4.in_ready); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            drive4(idx < 5, 1, 0, addrs[idx < 5 ? idx : 0], 1, 0);
            #1;
            if (npop < 5) begin
                n_checks++;
                if (b4.out_valid !== 1'b1 || b4.out_rd !== 1'b1 || b4.tag_proc !== f_tag(addrs[npop]) ||
                    b4.index_proc !== f_idx(addrs[npop]) || b4.blk_offset_proc !== f_off(addrs[npop]))
                    $display("FAIL order_pop%0d got v%b rd%b %h/%h/%h exp %h/%h/%h", npop, b4.out_valid, b4.out_rd,
                             b4.tag_proc, b4.index_proc, b4.blk_offset_proc,
                             f_tag(addrs[npop]), f_idx(addrs[npop]), f_off(addrs[npop]));
                else n_pass++;
            end
            if (idx == 4 && b4.in_ready) begin
                n_checks++; if (cnt4 !== 3'd3) $display("FAIL fifth_accept_count got %0d exp 3", cnt4); else n_pass++;
            end
            model_edge4(acc, pp);
            if (acc) idx++;
            if (pp) npop++;
        end
        n_checks++; if (cnt4 !== 3'd0 || idx != 5) $display("FAIL full_drain got count %0d accepted %0d exp 0 5", cnt4, idx); else n_pass++;
    endtask

    task automatic test_stream();
        bit acc, pp, r;
        for (int k = 0; k < 2; k++) begin
            r = 1'($urandom);
            drive4(1, r, !r, $urandom, 0, 0);
            model_edge4(acc, pp);
        end
        for (int k = 0; k < 20; k++) begin
            r = 1'($urandom);
            drive4(1, r, !r, $urandom, 1, 0);
            #1;
            n_checks++;
            if ({b4.out_rd, b4.out_wr} !== {mq[0].rd, mq[0].wr} || b4.tag_proc !== f_tag(mq[0].a) ||
                b4.index_proc !== f_idx(mq[0].a) || b4.blk_offset_proc !== f_off(mq[0].a))
                $display("FAIL stream_head%0d got %b%b %h/%h/%h exp %b%b %h", k, b4.out_rd, b4.out_wr,
                         b4.tag_proc, b4.index_proc, b4.blk_offset_proc, mq[0].rd, mq[0].wr, mq[0].a);
            else n_pass++;
            model_edge4(acc, pp);
            n_checks++; if (cnt4 !== 3'd2) $display("FAIL stream_count%0d got %0d exp 2", k, cnt4); else n_pass++;
        end
        drive4(0, 0, 0, 0, 1, 0);
        model_edge4(acc, pp);
        model_edge4(acc, pp);
    endtask

    task automatic test_err_cmd();
        bit acc, pp;
        drive4(1, 1, 0, $urandom, 0, 0);
        model_edge4(acc, pp);
        drive4(1, 1, 1, $urandom, 0, 0);
        model_edge4(acc, pp);
        drive4(0, 0, 0, 0, 0, 0);
        #1;
        n_checks++; if (err4 !== 1'b1) $display("FAIL err_pulse got %b exp 1", err4); else n_pass++;
        n_checks++; if (cnt4 !== 3'd1) $display("FAIL err_no_push got %0d exp 1", cnt4); else n_pass++;
        model_edge4(acc, pp);
        n_checks++; if (err4 !== 1'b0) $display("FAIL err_one_cycle got %b exp 0", err4); else n_pass++;
        drive4(1, 0, 0, $urandom, 0, 0);
        model_edge4(acc, pp);
        n_checks++; if (err4 !== 1'b0 || cnt4 !== 3'd1) $display("FAIL neither_cmd got err %b count %0d exp 0 1", err4, cnt4); else n_pass++;
        drive4(0, 0, 0, 0, 1, 0);
        model_edge4(acc, pp);
    endtask

    task automatic test_flush();
        bit acc, pp;
        for (int k = 0; k < 3; k++) begin
            drive4(1, 0, 1, $urandom, 0, 0);
            model_edge4(acc, pp);
        end
        drive4(1, 1, 0, $urandom, 1, 1);
        #1;
        n_checks++; if (b4.in_ready !== 1'b0) $display("FAIL flush_in_ready got %b exp 0", b4.in_ready); else n_pass++;
        model_edge4(acc, pp);
        drive4(0, 0, 0, 0, 0, 0);
        #1;
        n_checks++; if (cnt4 !== 3'd0 || b4.out_valid !== 1'b0) $display("FAIL flush_clear got count %0d valid %b exp 0 0", cnt4, b4.out_valid); else n_pass++;
        n_checks++; if ({b4.out_rd, b4.out_wr, b4.tag_proc, b4.index_proc, b4.blk_offset_proc, err4} !== '0)
            $display("FAIL flush_idle_zero got %b%b %h %h %h err %b exp 0", b4.out_rd, b4.out_wr, b4.tag_proc,
                     b4.index_proc, b4.blk_offset_proc, err4);
        else n_pass++;
        model_edge4(acc, pp);
        n_checks++; if (cnt4 !== 3'd0) $display("FAIL flush_no_enqueue got %0d exp 0", cnt4); else n_pass++;
    endtask

    // DEPTH=3: the write pointer wraps 2->0, a case a power-of-2 depth never exercises.
    task automatic test_wrap_d3();
        logic [31:0] q3[$];
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            a = $urandom;
            b3.in_valid = 1; b3.cmd_rd = 0; b3.cmd_wr = 1; b3.address = a; b3.out_ready = 0;
            @(posedge clk); q3.push_back(a); @(negedge clk);
        end
        for (int k = 0; k < 20; k++) begin
            a = $urandom;
            b3.address = a; b3.out_ready = 1;
            #1;
            n_checks++;
            if (b3.out_wr !== 1'b1 || b3.tag_proc !== f_tag(q3[0]) || b3.index_proc !== f_idx(q3[0]) ||
                b3.blk_offset_proc !== f_off(q3[0]))
                $display("FAIL d3_head%0d got %h/%h/%h exp %h", k, b3.tag_proc, b3.index_proc, b3.blk_offset_proc, q3[0]);
            else n_pass++;
            @(posedge clk); void'(q3.pop_front()); q3.push_back(a); @(negedge clk);
            n_checks++; if (cnt3 !== 2'd2) $display("FAIL d3_count%0d got %0d exp 2", k, cnt3); else n_pass++;
        end
        b3.out_ready = 0; b3.address = $urandom;
        @(negedge clk);
        #1;
        n_checks++; if (cnt3 !== 2'd3 || b3.in_ready !== 1'b0) $display("FAIL d3_full got count %0d ready %b exp 3 0", cnt3, b3.in_ready); else n_pass++;
        b3.in_valid = 0;
    endtask

    task automatic test_async_reset();
        bit acc, pp;
        for (int k = 0; k < 2; k++) begin
            drive4(1, 1, 0, $urandom, 0, 0);
            model_edge4(acc, pp);
        end
        drive4(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (cnt4 !== 3'd0 || b4.out_valid !== 1'b0) $display("FAIL async_reset got count %0d valid %b exp 0 0", cnt4, b4.out_valid); else n_pass++;
        n_checks++; if (b4.in_ready !== 1'b1 || b4.tag_proc !== '0) $display("FAIL async_reset_ready got %b tag %h exp 1 0", b4.in_ready, b4.tag_proc); else n_pass++;
        mq.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit acc, pp, v, o, f;
        int r;
        logic [31:0] a;
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            v = ($urandom_range(0, 9) < 7);
            o = ($urandom_range(0, 9) < 5);
            f = ($urandom_range(0, 29) == 0);
            a = $urandom;
            drive4(v, r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, a, o, f);
            #1;
            n_checks++; if (b4.in_ready !== ((mq.size() != D) && !f)) $display("FAIL rnd_in_ready%0d got %b exp %b", k, b4.in_ready, (mq.size() != D) && !f); else n_pass++;
            model_edge4(acc, pp);
            n_checks++; if (cnt4 !== 3'(mq.size()) || err4 !== exp_err) $display("FAIL rnd_state%0d got count %0d err %b exp %0d %b", k, cnt4, err4, mq.size(), exp_err); else n_pass++;
            n_checks++;
            if (mq.size() == 0) begin
                if ({b4.out_valid, b4.out_rd, b4.out_wr, b4.tag_proc, b4.index_proc, b4.blk_offset_proc} !== '0)
                    $display("FAIL rnd_idle%0d got v%b %b%b %h/%h/%h exp 0", k, b4.out_valid, b4.out_rd, b4.out_wr,
                             b4.tag_proc, b4.index_proc, b4.blk_offset_proc);
                else n_pass++;
            end else if (b4.out_valid !== 1'b1 || {b4.out_rd, b4.out_wr} !== {mq[0].rd, mq[0].wr} ||
                         b4.tag_proc !== f_tag(mq[0].a) || b4.index_proc !== f_idx(mq[0].a) ||
                         b4.blk_offset_proc !== f_off(mq[0].a))
                $display("FAIL rnd_head%0d got v%b %b%b %h/%h/%h exp %b%b %h", k, b4.out_valid, b4.out_rd, b4.out_wr,
                         b4.tag_proc, b4.index_proc, b4.blk_offset_proc, mq[0].rd, mq[0].wr, mq[0].a);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        drive4(0, 0, 0, 0, 0, 0);
        b3.in_valid = 0; b3.cmd_rd = 0; b3.cmd_wr = 0; b3.address = '0; b3.out_ready = 0;
        flush3 = 0;
        exp_err = 0;
        @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single_write();
        test_fill_full();
        test_stream();
        test_err_cmd();
        test_flush();
        test_wrap_d3();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
